math_pipelined_arbiter: RTL and testbench
=========================================

MATH_PIPELINED_ARBITER -- requirements
Module: math_pipelined_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand/result width in bits.
REQ-002 The block SHALL have parameter LATENCY, default 4: fixed cycles from alu_issue to alu_result of the shared pipelined unit.
REQ-003 The block SHALL have parameter REQUESTERS, default 4: number of requester ports; minimum 2.
REQ-004 The block SHALL have parameter OP_W, default 2: opcode width; opcodes pass through opaquely.
REQ-005 The block SHALL have the following ports, one clock and synchronous active-low reset:
  clk  input  1  sole clock; all state on rising edge
  rst_n  input  1  synchronous, active-low reset
  req_valid  input  REQUESTERS  per-requester operation request
  req_ready  output  REQUESTERS  per-requester accept (one-hot or zero)
  req_op  input  REQUESTERS*OP_W  packed opcodes, requester i at [i*OP_W+:OP_W]
  req_a  input  REQUESTERS*WIDTH  packed operand A
  req_b  input  REQUESTERS*WIDTH  packed operand B
  drain  input  1  blocks new grants while high
  alu_issue  output  1  registered issue strobe to shared unit
  alu_op  output  OP_W  registered opcode
  alu_a  output  WIDTH  registered operand A
  alu_b  output  WIDTH  registered operand B
  alu_result  input  WIDTH  shared unit result, valid LATENCY cycles after alu_issue
  rsp_valid  output  REQUESTERS  one-cycle, one-hot result strobe to originating requester
  rsp_data  output  WIDTH  equals alu_result
  in_flight  output  clog2(LATENCY+2)  accepted-but-unreturned operations
  idle  output  1  high when in_flight==0 and alu_issue==0

Function
REQ-006 Transfer on port i SHALL occur in a cycle where req_valid[i] && req_ready[i].
REQ-007 req_ready SHALL be combinational: at most one bit high; all zero when drain=1 or rst_n=0.
REQ-008 Arbitration SHALL be round-robin: search starts at last-granted index +1, wrapping at REQUESTERS-1 -> 0; first valid requester wins.
REQ-009 The round-robin pointer SHALL update only on a transfer, to the granted index.
REQ-010 At most one transfer per cycle; full throughput (one issue every cycle) SHALL be sustained with no bubbles.
REQ-011 A transfer in cycle t SHALL produce alu_issue=1 with captured op/a/b in cycle t+1; alu_issue=0 otherwise; alu_op/a/b hold last value when not issuing.
REQ-012 A tag pipeline of LATENCY+1 stages SHALL carry {valid, requester id} alongside each transfer.
REQ-013 rsp_valid[id] SHALL pulse in cycle t+1+LATENCY for a transfer in cycle t; rsp_data=alu_result in that cycle; no response backpressure exists.
REQ-014 in_flight SHALL increment on transfer, decrement on any rsp_valid, and be unchanged when both occur in one cycle; it never exceeds LATENCY+1.
REQ-015 Requester holding req_valid without ready SHALL retain its request; operands sampled only in the transfer cycle.
REQ-016 drain asserted mid-stream SHALL not cancel in-flight operations; their responses SHALL still return; idle rises once the pipeline empties.
REQ-017 Responses SHALL return in issue order regardless of requester id.

Reset
REQ-018 When rst_n=0 at a rising edge: tag pipeline cleared, alu_issue=0, alu_op/a/b=0, in_flight=0, pointer=REQUESTERS-1 (so requester 0 has first priority).
REQ-019 Reset mid-operation SHALL discard all in-flight tags; no rsp_valid SHALL occur for operations accepted before reset.
REQ-020 In the cycle following reset release, rsp_valid=0, idle=1.

Structure
REQ-021 Opcode constants (ADD=0, SUB=1, AND=2, XOR=3) and the clog2 helper SHALL reside in the shared toolbox include file, not in this module.
REQ-022 The round-robin grant logic SHALL be a separate sub-module, rr_arbiter (parameter N; inputs request, pointer; output one-hot grant).
REQ-023 The shared pipelined unit SHALL be external; the block only sequences it.

Verification (WIDTH=8, LATENCY=4, REQUESTERS=4, bench ALU model returns a+b)
REQ-024 Single request: req 2 valid, a=0x10, b=0x05 at t -> alu_issue at t+1, rsp_valid=4'b0100, rsp_data=0x15 at t+5.
REQ-025 All four valid continuously after reset -> grants 0,1,2,3,0 in consecutive cycles; responses one per cycle in the same order.
REQ-026 Wrap-around: a=0xFF, b=0x01 -> rsp_data=0x00 with rsp to correct requester.
REQ-027 drain raised after 3 transfers -> req_ready=0 immediately, 3 responses still returned, in_flight 3->0, idle=1 after the last response.
REQ-028 rst_n low for 1 cycle with 4 operations in flight -> no rsp_valid afterwards, in_flight=0, next grant goes to requester 0.
REQ-029 Simultaneous transfer and response in steady streaming -> in_flight constant at 5.

Source files
------------

// File: rtl/math_pipelined_arbiter_pkg.sv
// Shared toolbox for the pipelined-unit arbiter: opcode encodings and the
// ceil-log2 helper used to size pointers, tags and counters.
package math_pipelined_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } alu_op_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/math_pipelined_arbiter_if.sv
// Request/issue/response bundle between requesters, the arbiter and the
// external pipelined unit. slave = arbiter side, master = environment side.
interface math_pipelined_arbiter_if #(
  parameter int WIDTH      = 4,
  parameter int LATENCY    = 4,
  parameter int REQUESTERS = 4,
  parameter int OP_W       = 2,
  parameter int IFW        = math_pipelined_arbiter_pkg::clog2(LATENCY + 2)
);
  logic [REQUESTERS-1:0]       req_valid;
  logic [REQUESTERS-1:0]       req_ready;
  logic [REQUESTERS*OP_W-1:0]  req_op;
  logic [REQUESTERS*WIDTH-1:0] req_a;
  logic [REQUESTERS*WIDTH-1:0] req_b;
  logic                        drain;
  logic                        alu_issue;
  logic [OP_W-1:0]             alu_op;
  logic [WIDTH-1:0]            alu_a;
  logic [WIDTH-1:0]            alu_b;
  logic [WIDTH-1:0]            alu_result;
  logic [REQUESTERS-1:0]       rsp_valid;
  logic [WIDTH-1:0]            rsp_data;
  logic [IFW-1:0]              in_flight;
  logic                        idle;

  modport slave (
    input  req_valid, req_op, req_a, req_b, drain, alu_result,
    output req_ready, alu_issue, alu_op, alu_a, alu_b,
           rsp_valid, rsp_data, in_flight, idle
  );

  modport master (
    output req_valid, req_op, req_a, req_b, drain, alu_result,
    input  req_ready, alu_issue, alu_op, alu_a, alu_b,
           rsp_valid, rsp_data, in_flight, idle
  );
endinterface

// File: rtl/math_pipelined_arbiter_rr_arbiter.sv
// Round-robin grant: search begins one past the pointer and wraps; the
// pointer's own index has lowest priority. Purely combinational.
module rr_arbiter import math_pipelined_arbiter_pkg::*; #(
  parameter  int N   = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] pointer,
  output logic [N-1:0]   grant
);

  int idx;

  // Walk from farthest to nearest so the nearest valid requester overwrites.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(pointer) + off) % N;
      if (request[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/math_pipelined_arbiter.sv
// Arbitrates REQUESTERS onto one external fixed-latency pipelined unit,
// registers the issue, and routes each result back via a requester-id tag pipe.
module math_pipelined_arbiter import math_pipelined_arbiter_pkg::*; #(
  parameter int WIDTH      = 4,
  parameter int LATENCY    = 4,
  parameter int REQUESTERS = 4,
  parameter int OP_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  math_pipelined_arbiter_if.slave     bus
);

  localparam int IDW = clog2(REQUESTERS);
  localparam int IFW = clog2(LATENCY + 2);

  logic [REQUESTERS-1:0]          gnt;
  logic [IDW-1:0]                 gnt_id;
  logic                           xfer;
  logic                           rsp_fire;

  logic [IDW-1:0]                 ptr_q, ptr_d;
  logic                           alu_issue_q;
  logic [OP_W-1:0]                alu_op_q, alu_op_d;
  logic [WIDTH-1:0]               alu_a_q, alu_a_d;
  logic [WIDTH-1:0]               alu_b_q, alu_b_d;
  logic [IFW-1:0]                 in_flight_q, in_flight_d;
  logic [LATENCY:0]               vld_pipe;
  logic [LATENCY:0][IDW-1:0]      id_pipe;

  rr_arbiter #(.N(REQUESTERS)) u_arb (
    .request (bus.req_valid),
    .pointer (ptr_q),
    .grant   (gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < REQUESTERS; i++)
      if (gnt[i]) gnt_id = IDW'(i);
  end

  // Grant only contains valid requesters, so any ready bit is a transfer.
  assign xfer          = rst_n && !bus.drain && (|gnt);
  assign bus.req_ready = xfer ? gnt : '0;

  always_comb begin
    ptr_d    = ptr_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    if (xfer) begin
      ptr_d    = gnt_id;
      alu_op_d = bus.req_op[int'(gnt_id)*OP_W +: OP_W];
      alu_a_d  = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
      alu_b_d  = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
    end
  end

  // Last tag stage lines up with alu_result: LATENCY cycles after issue.
  assign rsp_fire = vld_pipe[LATENCY];

  always_comb begin
    bus.rsp_valid = '0;
    if (rsp_fire) bus.rsp_valid[id_pipe[LATENCY]] = 1'b1;
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (xfer && !rsp_fire)      in_flight_d = in_flight_q + IFW'(1);
    else if (!xfer && rsp_fire) in_flight_d = in_flight_q - IFW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= IDW'(REQUESTERS - 1);
      alu_issue_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      in_flight_q <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      alu_issue_q <= xfer;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      in_flight_q <= in_flight_d;
      vld_pipe    <= {vld_pipe[LATENCY-1:0], xfer};
      id_pipe     <= {id_pipe[LATENCY-1:0], gnt_id};
    end
  end

  assign bus.alu_issue = alu_issue_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_data  = bus.alu_result;
  assign bus.in_flight = in_flight_q;
  assign bus.idle      = (in_flight_q == '0) && !alu_issue_q;

endmodule

// File: tb/tb_math_pipelined_arbiter.sv
// Directed bench: stimulus pushes expected responses into a scoreboard and a
// negedge monitor pops/compares every rsp_valid; the shared unit is modelled as a+b.
module tb_math_pipelined_arbiter;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int R  = 4;
  localparam int OW = 2;

  typedef struct packed {
    logic [R-1:0] vld;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  math_pipelined_arbiter_if #(.WIDTH(W), .LATENCY(L), .REQUESTERS(R), .OP_W(OW)) bus ();

  math_pipelined_arbiter #(.WIDTH(W), .LATENCY(L), .REQUESTERS(R), .OP_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External unit model: result of an issue appears L cycles later.
  logic [W-1:0] alu_pipe [L];
  always @(posedge clk) begin
    alu_pipe[0] <= bus.alu_issue ? W'(bus.alu_a + bus.alu_b) : '0;
    for (int k = 1; k < L; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign bus.alu_result = alu_pipe[L-1];

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [W-1:0] sums [R];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [W-1:0] d);
    exp_t e;
    e.vld  = R'(1) << id;
    e.data = d;
    return e;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid !== '0) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
      else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op    = 8'b11_10_01_00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.drain     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b0001;
    #1 chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    chk("rst_issue", 32'(bus.alu_issue), 32'h0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_in_flight", 32'(bus.in_flight), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("post_rst_idle", 32'(bus.idle), 32'h1);

    // Single request from requester 2
    set_req(2, 8'h10, 8'h05);
    bus.req_valid = 4'b0100;
    #1 chk("single_ready", 32'(bus.req_ready), 32'h4);
    sb.push_back(mk(2, 8'h15));
    @(negedge clk);
    bus.req_valid = '0;
    chk("single_issue", 32'(bus.alu_issue), 32'h1);
    chk("single_alu_a", 32'(bus.alu_a), 32'h10);
    chk("single_alu_b", 32'(bus.alu_b), 32'h05);
    chk("single_in_flight", 32'(bus.in_flight), 32'h1);
    chk("single_busy", 32'(bus.idle), 32'h0);
    @(negedge clk);
    chk("issue_drop", 32'(bus.alu_issue), 32'h0);
    chk("alu_a_hold", 32'(bus.alu_a), 32'h10);
    repeat (2) @(negedge clk);
    chk("single_rsp_early", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    chk("single_rsp_lat", 32'(bus.rsp_valid), 32'h4);
    @(negedge clk);
    chk("single_done_if", 32'(bus.in_flight), 32'h0);
    chk("single_done_idle", 32'(bus.idle), 32'h1);

    // Round-robin streaming after reset; also steady-state in_flight
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < R; i++) begin
      sums[i] = W'(8'h10 * (i + 1) + i);
      set_req(i, W'(8'h10 * (i + 1)), W'(i));
    end
    bus.req_valid = 4'hF;
    for (int j = 0; j < 10; j++) begin
      #1 chk("rr_grant", 32'(bus.req_ready), 32'h1 << (j % 4));
      sb.push_back(mk(j % 4, sums[j % 4]));
      if (j >= 5) chk("steady_in_flight", 32'(bus.in_flight), 32'h5);
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (8) @(negedge clk);
    chk("stream_idle", 32'(bus.idle), 32'h1);
    chk("stream_drained", 32'(sb.size()), 32'h0);

    // Wrap-around sum to requester 3
    set_req(3, 8'hFF, 8'h01);
    bus.req_valid = 4'b1000;
    #1 chk("wrap_ready", 32'(bus.req_ready), 32'h8);
    sb.push_back(mk(3, 8'h00));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (6) @(negedge clk);
    chk("wrap_idle", 32'(bus.idle), 32'h1);

    // Drain after three transfers
    bus.req_valid = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      #1 chk("drain_pre_grant", 32'(bus.req_ready), 32'h1 << j);
      sb.push_back(mk(j, sums[j]));
      @(negedge clk);
    end
    bus.drain = 1'b1;
    #1 chk("drain_ready", 32'(bus.req_ready), 32'h0);
    chk("drain_if3", 32'(bus.in_flight), 32'h3);
    repeat (3) @(negedge clk);
    chk("drain_if2", 32'(bus.in_flight), 32'h2);
    @(negedge clk);
    chk("drain_if1", 32'(bus.in_flight), 32'h1);
    chk("drain_busy", 32'(bus.idle), 32'h0);
    @(negedge clk);
    chk("drain_if0", 32'(bus.in_flight), 32'h0);
    chk("drain_idle", 32'(bus.idle), 32'h1);
    chk("drain_ready_hold", 32'(bus.req_ready), 32'h0);
    bus.drain     = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);

    // Reset with four operations in flight
    bus.req_valid = 4'hF;
    repeat (4) @(negedge clk);
    chk("pre_rst_if", 32'(bus.in_flight), 32'h4);
    rst_n = 1'b0;
    #1 chk("rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("rst_flush_if", 32'(bus.in_flight), 32'h0);
    chk("rst_flush_idle", 32'(bus.idle), 32'h1);
    rst_n = 1'b1;
    #1 chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    sb.push_back(mk(0, sums[0]));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    chk("final_idle", 32'(bus.idle), 32'h1);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
